// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        SBC = 2'd3
    } addsub_op_e;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_pipe_rca_chunk.sv
// Combinational chunk adder: one CW-bit ripple segment of the pipelined carry chain.
module rca_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    // The carry into the MSB is recovered from the MSB sum bit and its operands
    assign cmsb = a[CW-1] ^ b[CW-1] ^ sum[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub/adc/sbc with valid/ready handshake and N/Z/C/V flags.
// The carry chain is cut into STAGES chunk-wide segments sharing one advance enable.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    logic             adv_s;
    logic [WIDTH-1:0] b_mode_s;
    logic             cin_mode_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;
    logic             out_ovf_r;
    logic             out_zero_r;
    logic             out_neg_r;

    // Bubbles are never collapsed: every stage moves only when the output slot frees up
    assign adv_s   = !out_valid_r || i_ready;
    assign o_ready = adv_s;

    // Operand B inversion and carry-in selection by mode
    always_comb begin
        b_mode_s   = i_b;
        cin_mode_s = 1'b0;
        case (addsub_op_e'(i_op))
            ADD: begin b_mode_s = i_b;  cin_mode_s = 1'b0;  end
            SUB: begin b_mode_s = ~i_b; cin_mode_s = 1'b1;  end
            ADC: begin b_mode_s = i_b;  cin_mode_s = i_cin; end
            SBC: begin b_mode_s = ~i_b; cin_mode_s = i_cin; end
            default: begin b_mode_s = i_b; cin_mode_s = 1'b0; end
        endcase
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Operand bits not yet added; resolved chunks leave the token as it advances
        localparam int IN_W = WIDTH - s * CW;

        logic [IN_W-1:0]       a_in_s;
        logic [IN_W-1:0]       b_in_s;
        logic                  valid_in_s;
        logic                  carry_in_s;
        logic [CW-1:0]         chunk_sum_s;
        logic                  chunk_cout_s;
        logic [(s+1)*CW-1:0]   sum_s;

        if (s == 0) begin : g_first
            assign a_in_s     = i_a;
            assign b_in_s     = b_mode_s;
            assign valid_in_s = i_valid;
            assign carry_in_s = cin_mode_s;
            assign sum_s      = chunk_sum_s;
        end else begin : g_rest
            assign a_in_s     = g_stage[s-1].g_reg.a_r;
            assign b_in_s     = g_stage[s-1].g_reg.b_r;
            assign valid_in_s = g_stage[s-1].g_reg.valid_r;
            assign carry_in_s = g_stage[s-1].g_reg.carry_r;
            assign sum_s      = {chunk_sum_s, g_stage[s-1].g_reg.sum_r};
        end

        if (s < STAGES - 1) begin : g_reg
            logic                 valid_r;
            logic                 carry_r;
            logic [IN_W-CW-1:0]   a_r;
            logic [IN_W-CW-1:0]   b_r;
            logic [(s+1)*CW-1:0]  sum_r;
            logic                 cmsb_unused;

            rca_chunk #(.CW(CW)) u_chunk (
                .a    (a_in_s[CW-1:0]),
                .b    (b_in_s[CW-1:0]),
                .cin  (carry_in_s),
                .sum  (chunk_sum_s),
                .cout (chunk_cout_s),
                .cmsb (cmsb_unused)
            );

            // Intermediate stage register: partial sum, chunk carry and remaining operands
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    valid_r <= 1'b0;
                    carry_r <= 1'b0;
                    a_r     <= {(IN_W-CW){1'b0}};
                    b_r     <= {(IN_W-CW){1'b0}};
                    sum_r   <= {((s+1)*CW){1'b0}};
                end else if (adv_s) begin
                    valid_r <= valid_in_s;
                    carry_r <= chunk_cout_s;
                    a_r     <= a_in_s[IN_W-1:CW];
                    b_r     <= b_in_s[IN_W-1:CW];
                    sum_r   <= sum_s;
                end
            end
        end else begin : g_out
            logic chunk_cmsb_s;

            rca_chunk #(.CW(CW)) u_chunk (
                .a    (a_in_s[CW-1:0]),
                .b    (b_in_s[CW-1:0]),
                .cin  (carry_in_s),
                .sum  (chunk_sum_s),
                .cout (chunk_cout_s),
                .cmsb (chunk_cmsb_s)
            );

            // Final stage register: full result plus flags, held while downstream stalls
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    out_valid_r <= 1'b0;
                    out_sum_r   <= {WIDTH{1'b0}};
                    out_cout_r  <= 1'b0;
                    out_ovf_r   <= 1'b0;
                    out_zero_r  <= 1'b0;
                    out_neg_r   <= 1'b0;
                end else if (adv_s) begin
                    out_valid_r <= valid_in_s;
                    out_sum_r   <= sum_s;
                    out_cout_r  <= chunk_cout_s;
                    out_ovf_r   <= chunk_cmsb_s ^ chunk_cout_s;
                    out_zero_r  <= (sum_s == {WIDTH{1'b0}});
                    out_neg_r   <= sum_s[WIDTH-1];
                end
            end
        end
    end

    assign o_valid = out_valid_r;
    assign o_sum   = out_sum_r;
    assign o_cout  = out_cout_r;
    assign o_ovf   = out_ovf_r;
    assign o_zero  = out_zero_r;
    assign o_neg   = out_neg_r;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the 32-bit ripple-carry adder.
- Splits the carry chain into STAGES registered segments so a wide add closes timing at the core clock.
- Adds a valid/ready handshake, an add/sub/carry mode and N/Z/C/V flags.
- Sits between the execute-stage operand muxes and consumers that need registered arithmetic results with backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline register stages; each stage resolves WIDTH/STAGES bits of the carry chain; STAGES >= 1.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_valid  in  1  input operands valid.
o_ready  out  1  block can accept input this cycle.
i_a  in  WIDTH  operand A.
i_b  in  WIDTH  operand B.
i_op  in  2  mode: ADD=0, SUB=1, ADC=2, SBC=3.
i_cin  in  1  carry in; used only by ADC/SBC.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts result.
o_sum  out  WIDTH  result.
o_cout  out  1  carry out of MSB (for SUB/SBC: 1 = no borrow).
o_ovf  out  1  signed overflow.
o_zero  out  1  o_sum == 0.
o_neg  out  1  o_sum[WIDTH-1].

Behaviour:
- One clock, i_clk; reset i_reset is asynchronous and active-high. While asserted, all stage valid bits, data and flag registers clear to 0, so o_valid=0, o_sum=0 and all flags=0. o_ready is 1 out of reset.
- Operand B and carry by mode:
  - ADD: B = i_b, carry = 0.
  - SUB: B = ~i_b, carry = 1.
  - ADC: B = i_b, carry = i_cin.
  - SBC: B = ~i_b, carry = i_cin (i_cin = 1 means no borrow).
- Advance: adv = !o_valid | i_ready. The whole pipeline shifts on a rising edge only when adv = 1. o_ready = adv, combinational.
- Accept: an input transfers when i_valid & o_ready. On a non-transfer advance, a bubble (valid = 0) enters stage 1.
- Stage k (1..STAGES) adds chunk k-1 of the operands with the carry registered by stage k-1. Stage 1 uses the mode carry.
  - Lower result chunks and the not-yet-added upper operand chunks, already B-inverted, travel with the token.
  - Only one chunk-wide carry chain lies between registers.
- Latency is exactly STAGES cycles from acceptance edge to o_valid, when i_ready is held 1.
- Throughput is 1 result per cycle. Bubbles are not collapsed: with o_valid=1 and i_ready=0, every stage holds, including empty ones.
- Flags are computed by the last stage and registered with o_sum:
  - o_cout = carry out of bit WIDTH-1.
  - o_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - o_zero and o_neg are derived from the final sum.
- Outputs stay stable while o_valid & !i_ready.
- If o_valid=1 and i_ready=1 on the same edge as a new input transfer, both happen: the result retires and a new token enters.
- Wrap-around is modulo 2^WIDTH; no saturation.
- Reset mid-operation discards all in-flight tokens; no result is produced for them.
- STAGES=1 degenerates to one registered full-width ripple adder with the same handshake.
- Handshake protocol assertions (bench):
  - i_valid must not drop, and i_a/i_b/i_op/i_cin must not change, while i_valid & !o_ready.
  - o_valid/o_sum/flags must not change while o_valid & !i_ready.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic [1:0] addsub_op_e {ADD, SUB, ADC, SBC}.
  - Localparam helper for chunk width CW = WIDTH/STAGES.
- Sub-module rca_chunk #(CW): purely combinational chunk adder.
  - Inputs a, b, cin.
  - Outputs sum, cout, cmsb (carry into its MSB, used for the overflow flag).
  - Instantiated STAGES times in a generate loop; pipeline registers live in addsub_pipe.

Test Plan:
1. Reset: assert i_reset mid-run with 3 tokens in flight -> o_valid=0, o_sum=0, all flags 0 immediately. After release, o_ready=1 and no stale result ever appears.
2. ADD 0xFFFFFFFF + 0x00000001, i_ready=1 -> after 4 cycles o_sum=0x00000000, cout=1, zero=1, ovf=0, neg=0.
3. SUB 0x80000000 - 0x00000001 -> o_sum=0x7FFFFFFF, cout=1, ovf=1, neg=0. SUB 0x00000005 - 0x00000007 -> 0xFFFFFFFE, cout=0, neg=1, ovf=0.
4. ADC 0x0000000F + 0x000000F0 with cin=1 -> 0x00000100, cout=0. SBC 0x10 - 0x01 with cin=0 -> 0x0000000E.
5. Backpressure: stream 8 back-to-back random ops while i_ready is held 0 for cycles 5-7.
   - o_ready falls and o_sum stays frozen throughout.
   - All 8 results arrive in order and match the reference model; none are lost or duplicated.
6. Parameter sweep with WIDTH=8 and STAGES in {1, 2, 8} on all 2^17 operand/cin combinations per op:
   - Results match the model, and latency equals STAGES.
   - Spot check: ADC 0x7F + 0x00 + 1 -> 0x80, ovf=1, neg=1.
